uart_frame_ctrl: RTL and testbench
==================================

// Module: uart_frame_ctrl
// PURPOSE
//  Frame controller downstream of uart_rx. Consumes its byte stream (data_out/data_valid/frame_error)
//  and sequences it into packets: SOF, LEN, LEN payload bytes, checksum. Validated payloads are held
//  in an internal buffer for a consumer, handshaked by frm_valid/frm_ack. Drops malformed or stalled frames.
// PARAMETERS
//  MAX_LEN     16      payload buffer depth in bytes; LEN legal range 1..MAX_LEN (MAX_LEN<=255)
//  SOF_BYTE    8'hAA   start-of-frame marker
//  TIMEOUT_CYC 20000   max clk cycles between consecutive bytes inside a frame (~4 byte times at 115200)
// PORTS
//  clk           in   1   50 MHz system clock
//  rst           in   1   asynchronous reset, active high
//  rx_data       in   8   byte from uart_rx data_out
//  rx_valid      in   1   1-cycle pulse, rx_data valid (uart_rx data_valid)
//  rx_ferr       in   1   1-cycle pulse, stop-bit error (uart_rx frame_error)
//  frm_rd_addr   in   $clog2(MAX_LEN)  payload buffer read address
//  frm_rd_data   out  8   buffer byte at frm_rd_addr, registered, 1-cycle latency
//  frm_len       out  8   LEN of held frame; valid while frm_valid
//  frm_valid     out  1   level: complete, checksum-good frame held
//  frm_ack       in   1   consumer releases held frame (sampled only in HOLD)
//  err_cksum     out  1   1-cycle pulse: checksum mismatch
//  err_len       out  1   1-cycle pulse: LEN==0 or LEN>MAX_LEN
//  err_frame     out  1   1-cycle pulse: rx_ferr seen inside a frame
//  err_timeout   out  1   1-cycle pulse: inter-byte timeout inside a frame
//  overrun       out  1   1-cycle pulse: byte arrived in HOLD and was dropped
//  state         out  3   current FSM state, debug only
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, byte counter/checksum/timeout counter 0; buffer contents undefined.
//  States: IDLE=0, LEN=1, PAYLOAD=2, CKSUM=3, HOLD=4.
//   IDLE: rx_valid & rx_data==SOF_BYTE -> LEN; other bytes silently discarded; rx_ferr ignored.
//   LEN: on rx_valid: 1<=rx_data<=MAX_LEN -> latch frm_len, csum<=rx_data, idx<=0, -> PAYLOAD;
//        else err_len pulse -> IDLE.
//   PAYLOAD: on rx_valid: buf[idx]<=rx_data, csum<=csum^rx_data; idx==frm_len-1 -> CKSUM else idx+1.
//   CKSUM: on rx_valid: rx_data==csum -> HOLD (frm_valid=1); else err_cksum pulse -> IDLE.
//   HOLD: frm_valid=1; frm_ack -> frm_valid=0 next cycle, -> IDLE; rx_valid -> byte dropped, overrun pulse.
//  Checksum: 8-bit XOR of LEN and all payload bytes; SOF excluded.
//  Latency: all transitions/pulses registered; checksum byte on cycle N -> frm_valid high at N+1.
//  Timeout: counter cleared on every rx_valid and on entering LEN; counts only in LEN/PAYLOAD/CKSUM;
//   reaching TIMEOUT_CYC-1 -> err_timeout pulse, -> IDLE. Held at 0 in IDLE/HOLD.
//  rx_ferr in LEN/PAYLOAD/CKSUM -> err_frame pulse, -> IDLE; rx_ferr beats rx_valid and timeout same cycle.
//  rx_ferr in HOLD: ignored, held frame preserved.
//  frm_ack outside HOLD ignored. frm_ack & rx_valid same cycle in HOLD: release and overrun both occur;
//   byte not parsed (SOF arriving exactly then is lost).
//  Buffer written only in PAYLOAD; contents stable throughout HOLD. A new frame overwrites from idx 0.
//  Error pulses mutually exclusive per cycle; at most one error per aborted frame.
//  rst asserted mid-frame or mid-HOLD: immediate return to reset values; partial frame discarded.
// CONFIGURATION
//  UART_FRAME_STATS_EN defined: adds outputs stat_good[15:0] (frames reaching HOLD) and stat_bad[15:0]
//   (count of err_len/err_cksum/err_frame/err_timeout pulses), saturating at 16'hFFFF, cleared by rst only.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  Good frame AA 03 11 22 33 03^11^22^33=03 -> frm_valid=1 1 cycle after last byte, frm_len=3,
//   rd_addr 0..2 -> 11,22,33 (1-cycle latency); frm_ack -> frm_valid=0, state=IDLE.
//  AA 02 10 20 00 (expected 32) -> err_cksum pulse once, frm_valid stays 0, state=IDLE.
//  AA 00 and AA 11 (MAX_LEN=16) -> err_len pulse each; following AA 01 5A 5B -> frm_valid, byte 5A.
//  AA 04 01 then silence TIMEOUT_CYC cycles -> err_timeout on that cycle, state=IDLE; no frm_valid.
//  In HOLD send byte 55 -> overrun pulse, buffer/frm_len unchanged; rx_ferr mid-PAYLOAD -> err_frame, IDLE.
//  rst pulse during PAYLOAD -> all outputs 0 immediately; with STATS_EN: 3 good + 2 bad -> 3/2.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// Packet framer behind uart_rx: SOF, LEN, LEN payload bytes, XOR checksum; holds good payloads for a consumer.
// Optional build macro UART_FRAME_STATS_EN adds saturating good/bad frame counters.
module uart_frame_ctrl #(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SOF_BYTE    = 8'hAA,
   parameter int         TIMEOUT_CYC = 20000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_valid,
   input  logic                       rx_ferr,
   input  logic [$clog2(MAX_LEN)-1:0] frm_rd_addr,
   output logic [7:0]                 frm_rd_data,
   output logic [7:0]                 frm_len,
   output logic                       frm_valid,
   input  logic                       frm_ack,
   output logic                       err_cksum,
   output logic                       err_len,
   output logic                       err_frame,
   output logic                       err_timeout,
   output logic                       overrun,
   output logic [2:0]                 state
`ifdef UART_FRAME_STATS_EN
  ,output logic [15:0]                stat_good,
   output logic [15:0]                stat_bad
`endif
);

   localparam int AW = $clog2(MAX_LEN);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CKSUM   = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   state_t          fsm_reg;
   logic [7:0]      csum_reg;
   logic [7:0]      idx_reg;
   logic [TW-1:0]   tmo_reg;
   logic [7:0]      buf_mem [MAX_LEN];
   logic            buf_we;
   logic            in_frame;

   assign state    = fsm_reg;
   assign in_frame = (fsm_reg == S_LEN) || (fsm_reg == S_PAYLOAD) || (fsm_reg == S_CKSUM);
   assign buf_we   = (fsm_reg == S_PAYLOAD) && rx_valid && !rx_ferr;

   always_ff @(posedge clk) begin
      if (buf_we)
         buf_mem[idx_reg[AW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frm_rd_data <= 8'd0;
      else
         frm_rd_data <= buf_mem[frm_rd_addr];
   end

   // Priority inside a frame: stop-bit error, then a received byte, then the inter-byte timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_reg     <= S_IDLE;
         frm_len     <= 8'd0;
         frm_valid   <= 1'b0;
         csum_reg    <= 8'd0;
         idx_reg     <= 8'd0;
         tmo_reg     <= '0;
         err_cksum   <= 1'b0;
         err_len     <= 1'b0;
         err_frame   <= 1'b0;
         err_timeout <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         err_cksum   <= 1'b0;
         err_len     <= 1'b0;
         err_frame   <= 1'b0;
         err_timeout <= 1'b0;
         overrun     <= 1'b0;
         case (fsm_reg)
            S_IDLE: begin
               tmo_reg <= '0;
               if (rx_valid && rx_data == SOF_BYTE)
                  fsm_reg <= S_LEN;
            end
            S_LEN, S_PAYLOAD, S_CKSUM: begin
               if (rx_ferr) begin
                  err_frame <= 1'b1;
                  tmo_reg   <= '0;
                  fsm_reg   <= S_IDLE;
               end else if (rx_valid) begin
                  tmo_reg <= '0;
                  if (fsm_reg == S_LEN) begin
                     if (rx_data != 8'd0 && rx_data <= 8'(MAX_LEN)) begin
                        frm_len  <= rx_data;
                        csum_reg <= rx_data;
                        idx_reg  <= 8'd0;
                        fsm_reg  <= S_PAYLOAD;
                     end else begin
                        err_len <= 1'b1;
                        fsm_reg <= S_IDLE;
                     end
                  end else if (fsm_reg == S_PAYLOAD) begin
                     csum_reg <= csum_reg ^ rx_data;
                     if (idx_reg == frm_len - 8'd1)
                        fsm_reg <= S_CKSUM;
                     else
                        idx_reg <= idx_reg + 8'd1;
                  end else begin
                     if (rx_data == csum_reg) begin
                        frm_valid <= 1'b1;
                        fsm_reg   <= S_HOLD;
                     end else begin
                        err_cksum <= 1'b1;
                        fsm_reg   <= S_IDLE;
                     end
                  end
               end else if (tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
                  err_timeout <= 1'b1;
                  tmo_reg     <= '0;
                  fsm_reg     <= S_IDLE;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            S_HOLD: begin
               tmo_reg <= '0;
               if (rx_valid)
                  overrun <= 1'b1;
               if (frm_ack) begin
                  frm_valid <= 1'b0;
                  fsm_reg   <= S_IDLE;
               end
            end
            default: begin
               tmo_reg <= '0;
               fsm_reg <= S_IDLE;
            end
         endcase
      end
   end

`ifdef UART_FRAME_STATS_EN
   logic good_evt;
   logic bad_evt;

   assign good_evt = (fsm_reg == S_CKSUM) && !rx_ferr && rx_valid && (rx_data == csum_reg);
   // Error pulses are counted the cycle after they appear; they are mutually exclusive.
   assign bad_evt  = err_len | err_cksum | err_frame | err_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_good <= 16'd0;
         stat_bad  <= 16'd0;
      end else begin
         if (good_evt && stat_good != 16'hFFFF)
            stat_good <= stat_good + 16'd1;
         if (bad_evt && stat_bad != 16'hFFFF)
            stat_bad <= stat_bad + 16'd1;
      end
   end
`endif

   logic unused_ok;
   assign unused_ok = in_frame;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: a queue-based frame model is compared against the DUT every cycle,
// and hand-computed literals pin the main scenarios.
module tb_uart_frame_ctrl;

   localparam int MAXL = 16;
   localparam int TMO  = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       rx_valid = 1'b0;
   logic       rx_ferr = 1'b0;
   logic       frm_ack = 1'b0;
   logic [3:0] frm_rd_addr = 4'd0;
   logic [7:0] frm_rd_data;
   logic [7:0] frm_len;
   logic       frm_valid;
   logic       err_cksum, err_len, err_frame, err_timeout, overrun;
   logic [2:0] state;
`ifdef UART_FRAME_STATS_EN
   logic [15:0] stat_good, stat_bad;
`endif

   always #5 clk = ~clk;

   uart_frame_ctrl #(.MAX_LEN(MAXL), .SOF_BYTE(8'hAA), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
      .frm_rd_addr(frm_rd_addr), .frm_rd_data(frm_rd_data), .frm_len(frm_len),
      .frm_valid(frm_valid), .frm_ack(frm_ack), .err_cksum(err_cksum), .err_len(err_len),
      .err_frame(err_frame), .err_timeout(err_timeout), .overrun(overrun), .state(state)
`ifdef UART_FRAME_STATS_EN
     ,.stat_good(stat_good), .stat_bad(stat_bad)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;
   int c_cksum = 0, c_len = 0, c_frame = 0, c_tmo = 0, c_ovr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: bytes seen since SOF are kept in a queue; position in the packet follows from its length.
   bit              m_in_frame = 0;
   bit              m_hold = 0;
   byte unsigned    m_got[$];
   int              m_len = 0;
   int              m_silent = 0;
   logic [7:0]      m_mem [MAXL];
   bit              m_known [MAXL];
   int              m_good = 0, m_bad = 0;

   logic [2:0] e_state;
   bit         e_cksum, e_elen, e_eframe, e_etmo, e_ovr;
   logic [7:0] e_rd;
   bit         e_rd_known = 0;

   task automatic model_step();
      int n;
      byte unsigned x;
      e_cksum = 0; e_elen = 0; e_eframe = 0; e_etmo = 0; e_ovr = 0;
      if (rst) begin
         m_in_frame = 0; m_hold = 0; m_got.delete(); m_len = 0; m_silent = 0;
         m_good = 0; m_bad = 0;
         for (int i = 0; i < MAXL; i++) m_known[i] = 0;
         e_rd = 8'd0; e_rd_known = 1;
      end else begin
         e_rd_known = m_known[frm_rd_addr];
         e_rd = m_mem[frm_rd_addr];
         if (m_hold) begin
            if (rx_valid) e_ovr = 1;
            if (frm_ack) m_hold = 0;
         end else if (!m_in_frame) begin
            if (rx_valid && rx_data == 8'hAA) begin
               m_in_frame = 1; m_got.delete(); m_silent = 0;
            end
         end else if (rx_ferr) begin
            e_eframe = 1; m_in_frame = 0;
         end else if (rx_valid) begin
            m_silent = 0;
            m_got.push_back(rx_data);
            n = m_got.size();
            if (n == 1) begin
               if (rx_data == 0 || rx_data > MAXL) begin e_elen = 1; m_in_frame = 0; end
               else m_len = rx_data;
            end else if (n <= m_len + 1) begin
               m_mem[n-2] = rx_data; m_known[n-2] = 1;
            end else begin
               x = 0;
               for (int i = 0; i < n - 1; i++) x ^= m_got[i];
               m_in_frame = 0;
               if (rx_data == x) begin m_hold = 1; m_good++; end
               else e_cksum = 1;
            end
         end else begin
            m_silent++;
            if (m_silent == TMO) begin e_etmo = 1; m_in_frame = 0; end
         end
         if (e_cksum || e_elen || e_eframe || e_etmo) m_bad++;
      end
      if (m_hold) e_state = 3'd4;
      else if (!m_in_frame) e_state = 3'd0;
      else if (m_got.size() == 0) e_state = 3'd1;
      else if (m_got.size() <= m_len) e_state = 3'd2;
      else e_state = 3'd3;
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      chk("state", state, e_state);
      chk("frm_valid", frm_valid, m_hold);
      if (m_hold) chk("frm_len", frm_len, m_len);
      chk("err_cksum", err_cksum, e_cksum);
      chk("err_len", err_len, e_elen);
      chk("err_frame", err_frame, e_eframe);
      chk("err_timeout", err_timeout, e_etmo);
      chk("overrun", overrun, e_ovr);
      if (e_rd_known) chk("frm_rd_data", frm_rd_data, e_rd);
      if (err_cksum) c_cksum++;
      if (err_len) c_len++;
      if (err_frame) c_frame++;
      if (err_timeout) c_tmo++;
      if (overrun) c_ovr++;
   end

   task automatic send_byte(input logic [7:0] d);
      @(negedge clk); rx_data = d; rx_valid = 1'b1;
      @(negedge clk); rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ack();
      @(negedge clk); frm_ack = 1'b1;
      @(negedge clk); frm_ack = 1'b0;
   endtask

   task automatic pulse_ferr();
      @(negedge clk); rx_ferr = 1'b1;
      @(negedge clk); rx_ferr = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
      @(negedge clk); frm_rd_addr = a;
      @(negedge clk); chk(name, frm_rd_data, exp);
   endtask

   int base;

   initial begin
      #1 rst = 1'b1;
      idle(3);
      rst = 1'b0;
      chk("reset_state", state, 3'd0);
      chk("reset_valid", frm_valid, 1'b0);
      chk("reset_len", frm_len, 8'd0);
      chk("reset_rd", frm_rd_data, 8'd0);

      // idle noise: ferr and ack outside a frame do nothing
      pulse_ferr();
      ack();
      send_byte(8'h55);

      // good frame
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h03);
      chk("good_valid", frm_valid, 1'b1);
      chk("good_len", frm_len, 8'd3);
      chk("good_state", state, 3'd4);
      read_chk("good_b0", 4'd0, 8'h11);
      read_chk("good_b1", 4'd1, 8'h22);
      read_chk("good_b2", 4'd2, 8'h33);
      ack();
      chk("ack_valid", frm_valid, 1'b0);
      chk("ack_state", state, 3'd0);

      // checksum error
      base = c_cksum;
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
      idle(2);
      chk("cksum_pulses", c_cksum - base, 1);
      chk("cksum_valid", frm_valid, 1'b0);
      chk("cksum_state", state, 3'd0);

      // illegal lengths, then a one-byte frame
      base = c_len;
      send_byte(8'hAA); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'h11);
      chk("len_pulses", c_len - base, 2);
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
      chk("len1_valid", frm_valid, 1'b1);
      read_chk("len1_b0", 4'd0, 8'h5A);
      ack();

      // maximum length: payload 00..0F, checksum 10^(xor 0..F)=10
      send_byte(8'hAA); send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      send_byte(8'h10);
      chk("max_valid", frm_valid, 1'b1);
      chk("max_len", frm_len, 8'd16);
      read_chk("max_b15", 4'd15, 8'h0F);
      ack();

      // inter-byte timeout
      base = c_tmo;
      send_byte(8'hAA); send_byte(8'h04); send_byte(8'h01);
      idle(TMO + 5);
      chk("tmo_pulses", c_tmo - base, 1);
      chk("tmo_state", state, 3'd0);
      chk("tmo_valid", frm_valid, 1'b0);

      // byte arriving TMO-1 cycles after the previous one is still accepted
      send_byte(8'hAA); send_byte(8'h02);
      idle(TMO - 3);
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
      chk("late_valid", frm_valid, 1'b1);

      // overrun and stop-bit error while held
      base = c_ovr;
      send_byte(8'h55);
      chk("ovr_pulses", c_ovr - base, 1);
      chk("ovr_len", frm_len, 8'd2);
      read_chk("ovr_b0", 4'd0, 8'h10);
      read_chk("ovr_b1", 4'd1, 8'h20);
      pulse_ferr();
      chk("hold_ferr_valid", frm_valid, 1'b1);
      @(negedge clk); frm_ack = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
      @(negedge clk); frm_ack = 1'b0; rx_valid = 1'b0;
      chk("ack_ovr_pulses", c_ovr - base, 2);
      chk("ack_sof_lost", state, 3'd0);

      // stop-bit error mid-payload, once alone and once together with a byte
      base = c_frame;
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
      pulse_ferr();
      chk("ferr_state", state, 3'd0);
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
      @(negedge clk); rx_ferr = 1'b1; rx_valid = 1'b1; rx_data = 8'h02;
      @(negedge clk); rx_ferr = 1'b0; rx_valid = 1'b0;
      chk("ferr_pulses", c_frame - base, 2);
      chk("ferr_state2", state, 3'd0);

      // reset mid-payload
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
      @(negedge clk); rst = 1'b1;
      #1;
      chk("rst_state", state, 3'd0);
      chk("rst_valid", frm_valid, 1'b0);
      chk("rst_len", frm_len, 8'd0);
      chk("rst_rd", frm_rd_data, 8'd0);
      @(negedge clk); rst = 1'b0;
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h77); send_byte(8'h76);
      chk("post_rst_valid", frm_valid, 1'b1);
      read_chk("post_rst_b0", 4'd0, 8'h77);
      ack();
      idle(3);

`ifdef UART_FRAME_STATS_EN
      chk("stat_good", stat_good, m_good);
      chk("stat_bad", stat_bad, m_bad);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
